// File: rtl/cache_l2_arbiter.sv
// rtl/cache_l2_arbiter.sv - two-port L1I/L1D arbiter in front of the shared L2 cache
//
// Purpose:
//   Shares the single CPU-side port of the unified L2 between the L1
//   instruction cache (I side) and the L1 data cache (D side). A grant is
//   latched in IDLE, exactly one requester's read or write is forwarded to
//   L2, and the L2 completion is routed back only to the granted side.
//   Contention is resolved by fixed D-side priority, or by round-robin when
//   the CACHE_L2_ARB_RR_EN macro is defined at compile time.
//
// Parameters:
//   ADDR_W    byte address width
//   LINE_W    cache line width in bits
//
// Ports:
//   clk                  system clock, rising edge
//   reset_n              asynchronous active-low reset
//   i_read / i_write     I-side request strobes
//   i_address / i_wdata  I-side line address / write line
//   i_resp / i_rdata     I-side completion / read line
//   d_read / d_write     D-side request strobes
//   d_address / d_wdata  D-side line address / write line
//   d_resp / d_rdata     D-side completion / read line
//   l2_read / l2_write   request strobes to L2
//   l2_address/l2_wdata  forwarded address / write line
//   l2_resp / l2_rdata   L2 completion / read line
//
// Build option:
//   CACHE_L2_ARB_RR_EN   round-robin arbitration on contention (adds rr_last)

module cache_l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,

  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic i_req;
  logic d_req;
  // High when a simultaneous I/D request in IDLE should go to the D side.
  logic contend_pick_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // ---------------------------------------------------------------------------
  // Contention policy
  // ---------------------------------------------------------------------------
`ifdef CACHE_L2_ARB_RR_EN
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  logic rr_last_q;
  logic rr_last_d;

  // The side that was not granted last wins a tie.
  assign contend_pick_d = (rr_last_q == SIDE_I);

  // rr_last follows every grant, contended or not.
  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_GRANT_I) begin
        rr_last_d = SIDE_I;
      end else if (state_d == ST_GRANT_D) begin
        rr_last_d = SIDE_D;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q <= SIDE_I;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  // Fixed priority: the data side always wins a tie.
  assign contend_pick_d = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Grant state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          state_d = contend_pick_d ? ST_GRANT_D : ST_GRANT_I;
        end else if (i_req) begin
          state_d = ST_GRANT_I;
        end else if (d_req) begin
          state_d = ST_GRANT_D;
        end
      end
      // Leave on completion, or if the requester abandons the request so
      // the port is not held by a side that no longer wants it.
      ST_GRANT_I: begin
        if (l2_resp || !i_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_D: begin
        if (l2_resp || !d_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding and response routing
  // ---------------------------------------------------------------------------
  // Outputs depend only on the registered grant, so an asynchronous reset
  // clears every strobe immediately. A read+write combination forwards the
  // read and suppresses the write.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      ST_GRANT_I: begin
        l2_read    = i_read;
        l2_write   = i_write & ~i_read;
        l2_address = i_address;
        l2_wdata   = i_wdata;
        i_resp     = l2_resp;
      end
      ST_GRANT_D: begin
        l2_read    = d_read;
        l2_write   = d_write & ~d_read;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each side qualifies it with its own resp.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_cache_l2_arbiter.sv
// tb/tb_cache_l2_arbiter.sv - self-checking bench for cache_l2_arbiter

module tb_cache_l2_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address, l2_address;
  logic [127:0] i_wdata, d_wdata, l2_wdata;
  logic         i_resp, d_resp, l2_read, l2_write, l2_resp;
  logic [127:0] i_rdata, d_rdata, l2_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Model-side outputs of the previous sampled cycle, used by the requesters.
  logic mdl_i_resp = 1'b0;
  logic mdl_d_resp = 1'b0;

  cache_l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the L2 port (0 none, 1 I, 2 D) and who was
  // granted last; outputs follow from the owner and the live request inputs.
  int owner = 0;
  int last  = 1;

  initial begin
    forever begin
      logic [3:0]   e_str;
      logic [15:0]  e_a;
      logic [127:0] e_w;
      bit iq, dq;
      @(negedge clk);
      iq = i_read | i_write;
      dq = d_read | d_write;
      e_str = 4'b0;
      e_a = 16'h0;
      e_w = 128'h0;
      if (!reset_n) begin
        owner = 0;
        last = 1;
      end else if (owner == 1) begin
        e_str = {i_read, i_write & ~i_read, l2_resp, 1'b0};
        e_a = i_address;
        e_w = i_wdata;
      end else if (owner == 2) begin
        e_str = {d_read, d_write & ~d_read, 1'b0, l2_resp};
        e_a = d_address;
        e_w = d_wdata;
      end
      chk("strobes{rd,wr,iresp,dresp}", {124'h0, l2_read, l2_write, i_resp, d_resp}, {124'h0, e_str});
      chk("l2_address", {112'h0, l2_address}, {112'h0, e_a});
      chk("l2_wdata", l2_wdata, e_w);
      chk("i_rdata", i_rdata, l2_rdata);
      chk("d_rdata", d_rdata, l2_rdata);
      mdl_i_resp = e_str[1];
      mdl_d_resp = e_str[0];
      if (reset_n) begin
        if (owner == 0) begin
          if (iq && dq) begin
`ifdef CACHE_L2_ARB_RR_EN
            owner = (last == 2) ? 1 : 2;
`else
            owner = 2;
`endif
          end else if (iq) begin
            owner = 1;
          end else if (dq) begin
            owner = 2;
          end
          if (owner != 0) last = owner;
        end else if (l2_resp || (owner == 1 && !iq) || (owner == 2 && !dq)) begin
          owner = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    l2_resp = 0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic gen_req(output logic rd, output logic wr, output logic [15:0] a,
                         output logic [127:0] w);
    int k;
    k = $urandom_range(0, 9);
    rd = (k < 5) || (k == 9);
    wr = (k >= 5);
    a = 16'($urandom);
    w = {$urandom, $urandom, $urandom, $urandom};
  endtask

  bit i_act, d_act, l2_busy;
  int l2_cnt;

  initial begin
    reset_n = 1'b0;
    i_read = 1; i_write = 0; i_address = 16'h0a00; i_wdata = 128'h0;
    d_read = 1; d_write = 0; d_address = 16'h0d00; d_wdata = 128'h0;
    l2_resp = 0; l2_rdata = 128'h0;

    // Reset with both sides requesting
    @(negedge clk);
    chk("reset strobes", {124'h0, l2_read, l2_write, i_resp, d_resp}, 128'h0);
    chk("reset l2_address", {112'h0, l2_address}, 128'h0);
    chk("reset l2_wdata", l2_wdata, 128'h0);
    step();
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-release idle l2_read", {127'h0, l2_read}, 128'h0);
    step();
    @(negedge clk);
    chk("post-release grant l2_read", {127'h0, l2_read}, 128'h1);
    chk("post-release grant address", {112'h0, l2_address}, 128'h0d00);

    // Single I read with 1-cycle L2
    do_reset();
    i_read = 1; i_address = 16'h0040;
    @(negedge clk);
    chk("ird cycle0 l2_read", {127'h0, l2_read}, 128'h0);
    step();
    @(negedge clk);
    chk("ird cycle1 l2_read", {127'h0, l2_read}, 128'h1);
    chk("ird cycle1 address", {112'h0, l2_address}, 128'h0040);
    step();
    l2_resp = 1; l2_rdata = {4{32'hA5A5A5A5}};
    @(negedge clk);
    chk("ird cycle2 i_resp", {127'h0, i_resp}, 128'h1);
    chk("ird cycle2 d_resp", {127'h0, d_resp}, 128'h0);
    chk("ird cycle2 i_rdata", i_rdata, {4{32'hA5A5A5A5}});
    step();
    l2_resp = 0; i_read = 0;
    @(negedge clk);
    chk("ird back to idle", {127'h0, l2_read}, 128'h0);

    // Single D write
    do_reset();
    d_write = 1; d_address = 16'h1230; d_wdata = 128'h1;
    step();
    @(negedge clk);
    chk("dwr strobes", {124'h0, l2_read, l2_write, i_resp, d_resp}, 128'b0100);
    chk("dwr address", {112'h0, l2_address}, 128'h1230);
    chk("dwr wdata", l2_wdata, 128'h1);
    step();
    l2_resp = 1;
    @(negedge clk);
    chk("dwr resp strobes", {124'h0, l2_read, l2_write, i_resp, d_resp}, 128'b0101);
    step();
    l2_resp = 0; d_write = 0;

    // Contention, both reads held
    do_reset();
    i_read = 1; i_address = 16'h1111;
    d_read = 1; d_address = 16'h2222;
    for (int g = 0; g < 3; g++) begin
      logic [15:0] exp_a;
`ifdef CACHE_L2_ARB_RR_EN
      exp_a = (g == 1) ? 16'h1111 : 16'h2222;
`else
      exp_a = 16'h2222;
`endif
      step();
      @(negedge clk);
      chk("contend grant address", {112'h0, l2_address}, {112'h0, exp_a});
      step();
      l2_resp = 1;
      @(negedge clk);
      chk("contend resp pair", {126'h0, i_resp, d_resp},
          (exp_a == 16'h1111) ? 128'b10 : 128'b01);
      step();
      l2_resp = 0;
    end

    // Reset in the middle of an I miss
    do_reset();
    i_read = 1; i_address = 16'h0abc;
    step();
    @(negedge clk);
    chk("midmiss grant l2_read", {127'h0, l2_read}, 128'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midmiss async l2_read", {127'h0, l2_read}, 128'h0);
    chk("midmiss async i_resp", {127'h0, i_resp}, 128'h0);
    step();
    i_read = 0;
    step();
    reset_n = 1'b1;

    // Read and write together on D
    do_reset();
    d_read = 1; d_write = 1; d_address = 16'h0777;
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) l2_resp = 1;
      @(negedge clk);
      chk("both-strobe rd/wr", {126'h0, l2_read, l2_write}, 128'b10);
      step();
    end
    l2_resp = 0; d_read = 0; d_write = 0;

    // Randomized traffic against a variable-latency L2
    do_reset();
    i_act = 0; d_act = 0; l2_busy = 0; l2_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (i_act) begin
        if (mdl_i_resp) begin
          if ($urandom_range(0, 1) == 1) gen_req(i_read, i_write, i_address, i_wdata);
          else begin i_read = 0; i_write = 0; i_act = 0; end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        gen_req(i_read, i_write, i_address, i_wdata);
        i_act = 1;
      end
      if (d_act) begin
        if (mdl_d_resp) begin
          if ($urandom_range(0, 1) == 1) gen_req(d_read, d_write, d_address, d_wdata);
          else begin d_read = 0; d_write = 0; d_act = 0; end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        gen_req(d_read, d_write, d_address, d_wdata);
        d_act = 1;
      end
      #1;
      if (l2_busy) begin
        if (l2_resp) begin
          l2_resp = 0;
          l2_busy = 0;
        end else begin
          l2_cnt--;
          if (l2_cnt == 0) begin
            l2_resp = 1;
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
      if (!l2_busy && (l2_read || l2_write)) begin
        l2_busy = 1;
        l2_cnt = $urandom_range(1, 3);
      end
    end

    step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
